// File: rtl/truth_table_sweeper_if.sv
// Config/status bundle between a test master and truth_table_sweeper.
// The master raises START with an expected truth table in EXPECT; the
// sweeper reports BUSY/DONE and the sampled table with its verdict.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  localparam int NV = 1 << N_IN;

  logic            START;
  logic [NV-1:0]   EXPECT;
  logic            BUSY;
  logic            DONE;
  logic [NV-1:0]   RESULT;
  logic            MATCH;
  logic [N_IN-1:0] ERR_IDX;

  modport master (
    output START, EXPECT,
    input  BUSY, DONE, RESULT, MATCH, ERR_IDX
  );

  modport slave (
    input  START, EXPECT,
    output BUSY, DONE, RESULT, MATCH, ERR_IDX
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for an N_IN-input combinational gate.
// Drives every vector 0..2^N_IN-1 on ABCD, holds each for SETTLE_CYCLES,
// samples F into RESULT and compares against the EXPECT captured at START.
// Optional build macro STOP_ON_MISMATCH_EN: end the sweep at the first
// mismatching sample instead of covering all vectors.
module truth_table_sweeper #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  truth_table_sweeper_if.slave cfg,
  input  logic                 F,
  output logic [N_IN-1:0]      ABCD
);
  localparam int NV    = 1 << N_IN;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    FINISH
  } state_e;

  state_e            state_q,    state_d;
  logic [N_IN-1:0]   abcd_q,     abcd_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [NV-1:0]     expect_q,   expect_d;
  logic [NV-1:0]     result_q,   result_d;
  logic              mismatch_q, mismatch_d;
  logic [N_IN-1:0]   err_idx_q,  err_idx_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              match_q,    match_d;

  logic              sample_miss;
  logic              end_sweep;

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    abcd_d      = abcd_q;
    cnt_d       = cnt_q;
    expect_d    = expect_q;
    result_d    = result_q;
    mismatch_d  = mismatch_q;
    err_idx_d   = err_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    match_d     = match_q;
    sample_miss = 1'b0;
    end_sweep   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg.START) begin
          expect_d   = cfg.EXPECT;
          result_d   = '0;
          match_d    = 1'b0;
          err_idx_d  = '0;
          mismatch_d = 1'b0;
          abcd_d     = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          result_d[abcd_q] = F;
          sample_miss      = (F != expect_q[abcd_q]);
          if (sample_miss && !mismatch_q) begin
            mismatch_d = 1'b1;
            err_idx_d  = abcd_q;
          end
`ifdef STOP_ON_MISMATCH_EN
          end_sweep = (abcd_q == VEC_LAST) || sample_miss;
`else
          end_sweep = (abcd_q == VEC_LAST);
`endif
          if (end_sweep) begin
            // The last sample's verdict is folded in here so MATCH is
            // valid in the same cycle DONE is.
            state_d = FINISH;
            done_d  = 1'b1;
            match_d = ~(mismatch_q | sample_miss);
            abcd_d  = '0;
          end else begin
            abcd_d = abcd_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset clears everything at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: RESULT and the expect table are plain flop vectors, not a RAM,
      // so they take the reset like every other register here.
      state_q    <= IDLE;
      abcd_q     <= '0;
      cnt_q      <= '0;
      expect_q   <= '0;
      result_q   <= '0;
      mismatch_q <= 1'b0;
      err_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      abcd_q     <= abcd_d;
      cnt_q      <= cnt_d;
      expect_q   <= expect_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      err_idx_q  <= err_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      match_q    <= match_d;
    end
  end

  assign ABCD        = abcd_q;
  assign cfg.BUSY    = busy_q;
  assign cfg.DONE    = done_q;
  assign cfg.RESULT  = result_q;
  assign cfg.MATCH   = match_q;
  assign cfg.ERR_IDX = err_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: directed sweeps against
// conditional_gate (F = ~B & D), busy-START, mid-sweep reset, a
// SETTLE_CYCLES = 3 instance, and random gate functions checked against a
// behavioural truth-table model.
module tb_truth_table_sweeper;
  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Instance 1: N_IN = 4, SETTLE_CYCLES = 1
  truth_table_sweeper_if #(.N_IN(4)) if1 ();
  logic [3:0]  abcd1;
  logic        f1;
  logic        use_rand;
  logic [15:0] gate_tt;

  // Instance 3: N_IN = 4, SETTLE_CYCLES = 3
  truth_table_sweeper_if #(.N_IN(4)) if3 ();
  logic [3:0]  abcd3;
  logic        f3;

  assign f1 = use_rand ? gate_tt[abcd1] : (~abcd1[2] & abcd1[0]);
  assign f3 = ~abcd3[2] & abcd3[0];

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .cfg   (if1.slave),
    .F     (f1),
    .ABCD  (abcd1)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(3)) dut3 (
    .CLK   (clk),
    .RST_N (rst_n),
    .cfg   (if3.slave),
    .F     (f3),
    .ABCD  (abcd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Truth table of F = ~B & D with A as the vector MSB.
  function automatic logic [15:0] cond_gate_tt();
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i] = (((i >> 2) & 1) == 0) && ((i & 1) == 1);
    return t;
  endfunction

  function automatic logic [15:0] tt_now();
    return use_rand ? gate_tt : cond_gate_tt();
  endfunction

  // Reference: walk the vectors in order, record F, note the first miss.
  function automatic void model(input logic [15:0] tt, input logic [15:0] ex,
                                output logic [15:0] res, output logic m,
                                output logic [3:0] err, output int nvec);
    res  = '0;
    m    = 1'b1;
    err  = '0;
    nvec = 16;
    for (int i = 0; i < 16; i++) begin
      res[i] = tt[i];
      if (tt[i] != ex[i] && m) begin
        m   = 1'b0;
        err = 4'(i);
`ifdef STOP_ON_MISMATCH_EN
        nvec = i + 1;
        break;
`endif
      end
    end
  endfunction

  // One sweep on instance 1. START is high during the cycle before edge e
  // for e == pa, e == pb, or e >= hold_from (hold_from > 0). EXPECT is
  // scrambled mid-sweep to show it is ignored once captured.
  task automatic sweep1(input logic [15:0] ex, input bit skip_start,
                        input int pa, input int pb, input int hold_from,
                        input string tag);
    logic [15:0] m_res;
    logic        m_match;
    logic [3:0]  m_err;
    int          nvec;
    model(tt_now(), ex, m_res, m_match, m_err, nvec);
    if1.EXPECT = ex;
    if (!skip_start) if1.START = 1'b1;
    @(posedge clk); #1;
    if1.START = 1'b0;
    check(tag, "acc_busy",   if1.BUSY,   1);
    check(tag, "acc_abcd",   abcd1,      0);
    check(tag, "acc_result", if1.RESULT, 0);
    check(tag, "acc_match",  if1.MATCH,  0);
    check(tag, "acc_done",   if1.DONE,   0);
    for (int e = 1; e <= nvec + 1; e++) begin
      if1.START = (e == pa) || (e == pb) || (hold_from > 0 && e >= hold_from);
      if (e == 3) if1.EXPECT = ~ex;
      @(posedge clk); #1;
      if (e < nvec) begin
        check(tag, "abcd", abcd1,    e);
        check(tag, "busy", if1.BUSY, 1);
        check(tag, "done", if1.DONE, 0);
      end else if (e == nvec) begin
        check(tag, "done_hi", if1.DONE,    1);
        check(tag, "busy_hi", if1.BUSY,    1);
        check(tag, "result",  if1.RESULT,  m_res);
        check(tag, "match",   if1.MATCH,   m_match);
        check(tag, "err_idx", if1.ERR_IDX, m_err);
      end else begin
        check(tag, "done_lo",   if1.DONE,    0);
        check(tag, "busy_lo",   if1.BUSY,    0);
        check(tag, "abcd_idle", abcd1,       0);
        check(tag, "result_h",  if1.RESULT,  m_res);
        check(tag, "match_h",   if1.MATCH,   m_match);
        check(tag, "err_h",     if1.ERR_IDX, m_err);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    use_rand   = 1'b0;
    gate_tt    = '0;
    if1.START  = 1'b0;
    if1.EXPECT = '0;
    if3.START  = 1'b0;
    if3.EXPECT = '0;

    // Reset state
    #12;
    check("reset", "abcd",   abcd1,       0);
    check("reset", "busy",   if1.BUSY,    0);
    check("reset", "done",   if1.DONE,    0);
    check("reset", "result", if1.RESULT,  0);
    check("reset", "match",  if1.MATCH,   0);
    check("reset", "err",    if1.ERR_IDX, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sweeps against conditional_gate
    sweep1(16'h0A0A, 1'b0, -1, -1, 0, "basic");
    repeat (3) @(posedge clk);
    #1;
    check("hold", "result", if1.RESULT, 16'h0A0A);
    check("hold", "match",  if1.MATCH,  1);
    check("hold", "busy",   if1.BUSY,   0);
    sweep1(16'h0A0B, 1'b0, -1, -1, 0, "mis0");
    sweep1(16'h0B0A, 1'b0, -1, -1, 0, "mis8");

    // SETTLE_CYCLES = 3 instance
    if3.EXPECT = 16'h0A0A;
    if3.START  = 1'b1;
    @(posedge clk); #1;
    if3.START  = 1'b0;
    check("settle3", "acc_busy", if3.BUSY, 1);
    for (int e = 1; e <= 49; e++) begin
      @(posedge clk); #1;
      if (e < 48) begin
        check("settle3", "abcd", abcd3,    e / 3);
        check("settle3", "done", if3.DONE, 0);
      end else if (e == 48) begin
        check("settle3", "done_hi", if3.DONE,    1);
        check("settle3", "result",  if3.RESULT,  16'h0A0A);
        check("settle3", "match",   if3.MATCH,   1);
        check("settle3", "err_idx", if3.ERR_IDX, 0);
      end else begin
        check("settle3", "done_lo", if3.DONE, 0);
        check("settle3", "busy_lo", if3.BUSY, 0);
      end
    end

    // START pulses mid-sweep, then START held through FINISH
    sweep1(16'h0A0A, 1'b0, 6, 11, 14, "busy_start");
    sweep1(16'h0A0A, 1'b1, -1, -1, 0, "restart");

    // Reset asserted mid-sweep while ABCD = 7
    if1.EXPECT = 16'h0A0A;
    if1.START  = 1'b1;
    @(posedge clk); #1;
    if1.START  = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst", "abcd_pre", abcd1, 7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst", "abcd",   abcd1,       0);
    check("midrst", "busy",   if1.BUSY,    0);
    check("midrst", "result", if1.RESULT,  0);
    check("midrst", "match",  if1.MATCH,   0);
    check("midrst", "err",    if1.ERR_IDX, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("midrst", "no_done", if1.DONE, 0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst", "idle_done", if1.DONE, 0);
    sweep1(16'h0A0A, 1'b0, -1, -1, 0, "post_rst");

    // Random gate functions against the model
    use_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      logic [15:0] ex;
      gate_tt = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       ex = gate_tt;
        1:       ex = gate_tt ^ (16'h1 << $urandom_range(0, 15));
        default: ex = 16'($urandom);
      endcase
      sweep1(ex, 1'b0, -1, -1, 0, "rand");
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
